// File: rtl/gnrl_demux16_pkg.sv
// ---------------------------------------------------------------------------
// gnrl_demux16_pkg
// Shared constants and types for the 16-lane priority select used by both the
// demux16 dispatcher and the mux16 selector.
//
// Contents:
//   DEMUX16_LANES     number of output lanes
//   DEMUX16_SEL_W     width of the priority select vector
//   DEMUX16_DFLT_LANE lane chosen when the select vector is all-zero
//   lane_onehot_t     16-bit one-hot lane vector
//   sel_is_multi_hot  true when more than one select bit is set
// ---------------------------------------------------------------------------
package gnrl_demux16_pkg;

   localparam int unsigned DEMUX16_LANES     = 16;
   localparam int unsigned DEMUX16_SEL_W     = 15;
   localparam int unsigned DEMUX16_DFLT_LANE = 15;

   typedef logic [DEMUX16_LANES-1:0] lane_onehot_t;
   typedef logic [DEMUX16_SEL_W-1:0] lane_sel_t;

   // Clearing the lowest set bit leaves a non-zero value only if another bit was set.
   function automatic logic sel_is_multi_hot(input lane_sel_t sel);
      return (sel & (sel - lane_sel_t'(1))) != '0;
   endfunction

endpackage

// File: rtl/pri_onehot16_module.sv
// ---------------------------------------------------------------------------
// pri_onehot16_module
// Combinational priority decode of a 15-bit select into a 16-bit one-hot lane.
// The lowest set select bit wins; an all-zero select picks the default lane
// (bit 15). Shared by the mux16 and demux16 sides so both decode identically.
//
// Ports:
//   sel     in   15-bit priority select
//   onehot  out  16-bit one-hot lane, exactly one bit set
// ---------------------------------------------------------------------------
module pri_onehot16_module
   import gnrl_demux16_pkg::*;
(
   input  logic [DEMUX16_SEL_W-1:0] sel,
   output logic [DEMUX16_LANES-1:0] onehot
);

   always_comb begin
      logic found;
      onehot = '0;
      found  = 1'b0;
      for (int i = 0; i < int'(DEMUX16_SEL_W); i++) begin
         if (sel[i] && !found) begin
            onehot[i] = 1'b1;
            found     = 1'b1;
         end
      end
      if (!found) begin
         onehot[DEMUX16_DFLT_LANE] = 1'b1;
      end
   end

endmodule

// File: rtl/demux16_module.sv
// ---------------------------------------------------------------------------
// demux16_module
// Registered 1-to-16 dispatcher with valid/ready flow control. One input beat
// (payload + priority select) is latched and offered to exactly one output
// lane until that lane accepts it. A draining beat may be replaced by a new
// one on the same edge, giving 1 beat/cycle sustained throughput.
//
// Optional feature (define DEMUX16_SEL_CHECK_EN): adds demux16_sel_err, a
// sticky flag set on any accepted beat whose select has more than one bit set.
//
// Ports:
//   clk                in   clock, rising edge
//   rst                in   synchronous active-high reset
//   demux16_in_valid   in   input beat valid
//   demux16_in_ready   out  beat can be accepted this cycle
//   demux16_sel        in   15-bit priority lane select
//   demux16_din        in   input payload
//   demux16_out_valid  out  per-lane valid, one-hot or zero
//   demux16_out_ready  in   per-lane ready
//   demux16_dout       out  shared payload bus for the flagged lane
//   demux16_sel_err    out  sticky multi-hot select flag (feature only)
// ---------------------------------------------------------------------------
module demux16_module
   import gnrl_demux16_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     demux16_in_valid,
   output logic                     demux16_in_ready,
   input  logic [DEMUX16_SEL_W-1:0] demux16_sel,
   input  logic [DATA_WIDTH-1:0]    demux16_din,
   output logic [DEMUX16_LANES-1:0] demux16_out_valid,
   input  logic [DEMUX16_LANES-1:0] demux16_out_ready,
   output logic [DATA_WIDTH-1:0]    demux16_dout
`ifdef DEMUX16_SEL_CHECK_EN
   ,
   output logic                     demux16_sel_err
`endif
);

   logic                  valid_q;
   lane_onehot_t          lane_q;
   logic [DATA_WIDTH-1:0] data_q;

   lane_onehot_t lane_dec;
   logic         drain;
   logic         accept;

   pri_onehot16_module u_pri_onehot16 (
      .sel    (demux16_sel),
      .onehot (lane_dec)
   );

   // Only the ready of the lane currently holding the beat matters.
   assign drain  = valid_q & |(lane_q & demux16_out_ready);
   // Combinational ready-through so a draining slot can refill on the same edge.
   assign demux16_in_ready = ~valid_q | drain;
   assign accept = demux16_in_valid & demux16_in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         lane_q  <= '0;
         data_q  <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         lane_q  <= lane_dec;
         data_q  <= demux16_din;
      end else if (drain) begin
         // Lane and data hold; only the valid flag drops.
         valid_q <= 1'b0;
      end
   end

   assign demux16_out_valid = valid_q ? lane_q : '0;
   assign demux16_dout      = data_q;

`ifdef DEMUX16_SEL_CHECK_EN
   logic sel_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_err_q <= 1'b0;
      end else if (accept && sel_is_multi_hot(demux16_sel)) begin
         sel_err_q <= 1'b1;
      end
   end

   assign demux16_sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_demux16_module.sv
module tb_demux16_module;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] sel;
   logic [31:0] din;
   logic [15:0] out_valid;
   logic [15:0] out_ready;
   logic [31:0] dout;
`ifdef DEMUX16_SEL_CHECK_EN
   logic        sel_err;
`endif

   int total;
   int bad;

   demux16_module #(
      .DATA_WIDTH (32)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .demux16_in_valid  (in_valid),
      .demux16_in_ready  (in_ready),
      .demux16_sel       (sel),
      .demux16_din       (din),
      .demux16_out_valid (out_valid),
      .demux16_out_ready (out_ready),
      .demux16_dout      (dout)
`ifdef DEMUX16_SEL_CHECK_EN
      ,
      .demux16_sel_err   (sel_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [15:0] exp_lane;
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      sel       = '0;
      din       = '0;
      out_ready = '0;

      // Reset
      step();
      step();
      check("rst_in_ready_during", 32'(in_ready), 32'd1);
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_dout", dout, 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef DEMUX16_SEL_CHECK_EN
      check("rst_sel_err", 32'(sel_err), 32'd0);
`endif
      step();
      check("idle_out_valid", 32'(out_valid), 32'h0);

      // Single beat on lane 3, held two cycles then drained
      sel      = 15'h0008;
      din      = 32'hCAFE0003;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      sel      = 15'h7FFF;
      din      = 32'hDEADBEEF;
      check("single_out_valid_c1", 32'(out_valid), 32'h0008);
      check("single_dout_c1", dout, 32'hCAFE0003);
      check("single_in_ready_c1", 32'(in_ready), 32'd0);
      step();
      check("single_out_valid_c2", 32'(out_valid), 32'h0008);
      check("single_in_ready_c2", 32'(in_ready), 32'd0);
      out_ready = 16'h0008;
      #1;
      check("single_in_ready_drain", 32'(in_ready), 32'd1);
      step();
      out_ready = '0;
      check("single_out_valid_after", 32'(out_valid), 32'h0);
      check("single_dout_hold", dout, 32'hCAFE0003);

      // Default lane for all-zero select
      sel       = 15'h0000;
      din       = 32'h0000000F;
      out_ready = 16'hFFFF;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      check("dflt_out_valid", 32'(out_valid), 32'h8000);
      check("dflt_dout", dout, 32'h0000000F);
      step();
      check("dflt_one_cycle", 32'(out_valid), 32'h0);

      // Multi-hot select: lowest bit (lane 1) wins
      out_ready = '0;
      sel       = 15'h4012;
      din       = 32'h12345678;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      check("multi_out_valid", 32'(out_valid), 32'h0002);
`ifdef DEMUX16_SEL_CHECK_EN
      check("multi_sel_err", 32'(sel_err), 32'd1);
`endif
      out_ready = 16'h4000;
      #1;
      check("multi_wrong_lane_ready", 32'(in_ready), 32'd0);
      step();
      check("multi_no_drain", 32'(out_valid), 32'h0002);
      check("multi_dout_hold", dout, 32'h12345678);
      out_ready = 16'h0002;
      step();
      check("multi_drained", 32'(out_valid), 32'h0);
`ifdef DEMUX16_SEL_CHECK_EN
      check("multi_sel_err_sticky", 32'(sel_err), 32'd1);
`endif

      // Back-to-back across all 16 lanes
      out_ready = 16'hFFFF;
      in_valid  = 1'b1;
      for (int k = 0; k < 16; k++) begin
         sel = (k == 15) ? 15'h0 : 15'(1 << k);
         din = 32'hB0000000 + 32'(k);
         check($sformatf("b2b_in_ready_%0d", k), 32'(in_ready), 32'd1);
         step();
         exp_lane = 16'(1 << k);
         check($sformatf("b2b_lane_%0d", k), 32'(out_valid), 32'(exp_lane));
         check($sformatf("b2b_data_%0d", k), dout, 32'hB0000000 + 32'(k));
      end
      in_valid = 1'b0;
      step();
      check("b2b_empty", 32'(out_valid), 32'h0);

      // Reset while a beat is held on lane 5
      out_ready = '0;
      sel       = 15'h0020;
      din       = 32'h00000055;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      check("midrst_held", 32'(out_valid), 32'h0020);
      step();
      check("midrst_held2", 32'(out_valid), 32'h0020);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'h0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_dout", dout, 32'h0);
`ifdef DEMUX16_SEL_CHECK_EN
      check("midrst_sel_err", 32'(sel_err), 32'd0);
`endif
      step();
      check("midrst_idle", 32'(out_valid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
